// File: rtl/battlecity_pkg.sv
// Shared types and constants for the Battle City enemy tank logic.
// Screen is 640x480; tanks are 32x32 sprites stepping 2 pixels per frame.
package battlecity_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_PROBE0,
        ST_PROBE1,
        ST_COMMIT,
        ST_FIRE
    } state_t;

    // AI control nibble layout {fire, move, dir[1:0]}
    localparam int CTL_FIRE = 3;
    localparam int CTL_MOVE = 2;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int TILE_SIZE = 16;

    localparam logic [COORD_W-1:0] X_START   = 10'd64;
    localparam logic [COORD_W-1:0] Y_START   = 10'd32;
    localparam logic [COORD_W-1:0] X_MIN     = 10'd0;
    localparam logic [COORD_W-1:0] X_MAX     = 10'd608;
    localparam logic [COORD_W-1:0] Y_MIN     = 10'd0;
    localparam logic [COORD_W-1:0] Y_MAX     = 10'd448;
    localparam logic [COORD_W-1:0] TANK_SIZE = 10'd32;
    localparam logic [COORD_W-1:0] STEP      = 10'd2;

    localparam int FIRE_CD     = 30;
    localparam int MAP_TIMEOUT = 64;
    localparam int CD_W        = 5;
    localparam int TO_W        = 6;

endpackage

// File: rtl/tank_edge_probe.sv
// Candidate position, bounds check and leading-edge probe corner for one step.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module tank_edge_probe
    import battlecity_pkg::*;
(
    input  dir_t               dir,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               idx,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               bounds_ok,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y
);

    localparam logic [COORD_W-1:0] FAR = TANK_SIZE - 10'd1;

    // One extra bit so x+STEP near the top of the range cannot wrap
    logic [COORD_W:0] x_inc;
    logic [COORD_W:0] y_inc;

    assign x_inc = {1'b0, x} + {1'b0, STEP};
    assign y_inc = {1'b0, y} + {1'b0, STEP};

    always_comb begin
        nx        = x;
        ny        = y;
        bounds_ok = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                nx        = x_inc[COORD_W-1:0];
                bounds_ok = (x_inc <= {1'b0, X_MAX});
            end
            DIR_LEFT: begin
                nx        = x - STEP;
                bounds_ok = (x >= X_MIN + STEP);
            end
            DIR_DOWN: begin
                ny        = y_inc[COORD_W-1:0];
                bounds_ok = (y_inc <= {1'b0, Y_MAX});
            end
            default: begin
                ny        = y - STEP;
                bounds_ok = (y >= Y_MIN + STEP);
            end
        endcase
    end

    always_comb begin
        probe_x = nx;
        probe_y = ny;
        case (dir)
            DIR_RIGHT: begin
                probe_x = nx + FAR;
                probe_y = idx ? ny + FAR : ny;
            end
            DIR_LEFT: begin
                probe_x = nx;
                probe_y = idx ? ny + FAR : ny;
            end
            DIR_DOWN: begin
                probe_x = idx ? nx + FAR : nx;
                probe_y = ny + FAR;
            end
            default: begin
                probe_x = idx ? nx + FAR : nx;
                probe_y = ny;
            end
        endcase
    end

endmodule

// File: rtl/ai_tank_driver.sv
// Per-frame enemy tank driver: turn, probe tile map, step, then request a bullet.
// Latency: position updates a few cycles after frame_tick plus map ack delays.
// Backpressure: map_req/fire_req held until ack; frame_tick outside IDLE is dropped.
module ai_tank_driver
    import battlecity_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic [3:0]         AI_tank_control,
    input  logic               tank_alive,
    output logic               map_req,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    input  logic               map_ack,
    input  logic               map_blocked,
    output logic [COORD_W-1:0] tank_x,
    output logic [COORD_W-1:0] tank_y,
    output logic [1:0]         tank_dir,
    output logic               fire_req,
    output logic [COORD_W-1:0] fire_x,
    output logic [COORD_W-1:0] fire_y,
    output logic [1:0]         fire_dir,
    input  logic               fire_ack
);

    localparam logic [COORD_W-1:0] HALF = TANK_SIZE >> 1;

    state_t            state;
    dir_t              lat_dir;
    logic              lat_fire;
    logic [CD_W-1:0]   cooldown;
    logic [TO_W-1:0]   to_cnt;

    dir_t               pdir;
    logic               pidx;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic               bounds_ok;
    logic [COORD_W-1:0] probe_x;
    logic [COORD_W-1:0] probe_y;

    logic               fire_bit;
    logic               want_fire;
    logic               probing;
    logic               probe_fail;
    logic               latch_skip;
    logic               seq_done;
    logic [COORD_W-1:0] base_x;
    logic [COORD_W-1:0] base_y;

    tank_edge_probe u_probe (
        .dir       (pdir),
        .x         (tank_x),
        .y         (tank_y),
        .idx       (pidx),
        .nx        (nx),
        .ny        (ny),
        .bounds_ok (bounds_ok),
        .probe_x   (probe_x),
        .probe_y   (probe_y)
    );

    // During LATCH the nibble is used live; afterwards the snapshot drives everything
    always_comb begin
        pdir       = (state == ST_LATCH) ? dir_t'(AI_tank_control[1:0]) : lat_dir;
        pidx       = (state != ST_LATCH);
        fire_bit   = (state == ST_LATCH) ? AI_tank_control[CTL_FIRE] : lat_fire;
        want_fire  = fire_bit && (cooldown == '0) && tank_alive;
        probing    = ((state == ST_PROBE0) || (state == ST_PROBE1)) && map_req;
        probe_fail = probing && (map_ack ? map_blocked
                                         : (to_cnt == TO_W'(MAP_TIMEOUT - 1)));
        latch_skip = (state == ST_LATCH) && !(AI_tank_control[CTL_MOVE] && bounds_ok);
        seq_done   = latch_skip || probe_fail || (state == ST_COMMIT);
        base_x     = (state == ST_COMMIT) ? nx : tank_x;
        base_y     = (state == ST_COMMIT) ? ny : tank_y;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            lat_dir  <= DIR_UP;
            lat_fire <= 1'b0;
            tank_x   <= X_START;
            tank_y   <= Y_START;
            tank_dir <= DIR_UP;
            map_req  <= 1'b0;
            map_x    <= '0;
            map_y    <= '0;
            fire_req <= 1'b0;
            fire_x   <= '0;
            fire_y   <= '0;
            fire_dir <= '0;
            cooldown <= '0;
            to_cnt   <= '0;
        end else begin
            if (frame_tick && (cooldown != '0)) begin
                cooldown <= cooldown - CD_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (frame_tick && tank_alive) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    lat_dir  <= pdir;
                    lat_fire <= AI_tank_control[CTL_FIRE];
                    tank_dir <= pdir;
                    if (!latch_skip) begin
                        state   <= ST_PROBE0;
                        map_req <= 1'b1;
                        map_x   <= probe_x;
                        map_y   <= probe_y;
                        to_cnt  <= '0;
                    end
                end
                ST_PROBE0: begin
                    if (map_req) begin
                        if (map_ack && !map_blocked) begin
                            // Drop the request for a cycle so the second corner is a fresh request
                            map_req <= 1'b0;
                            map_x   <= probe_x;
                            map_y   <= probe_y;
                            state   <= ST_PROBE1;
                        end else if (!map_ack) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                ST_PROBE1: begin
                    if (!map_req) begin
                        map_req <= 1'b1;
                        to_cnt  <= '0;
                    end else if (map_ack && !map_blocked) begin
                        map_req <= 1'b0;
                        state   <= ST_COMMIT;
                    end else if (!map_ack) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (tank_alive) begin
                        tank_x <= nx;
                        tank_y <= ny;
                    end
                end
                ST_FIRE: begin
                    if (fire_ack) begin
                        fire_req <= 1'b0;
                        cooldown <= CD_W'(FIRE_CD);
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Common exit of the movement phase: optionally raise a shot, else back to IDLE
            if (seq_done) begin
                map_req <= 1'b0;
                if (want_fire) begin
                    state    <= ST_FIRE;
                    fire_req <= 1'b1;
                    fire_x   <= base_x + HALF;
                    fire_y   <= base_y + HALF;
                    fire_dir <= pdir;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ai_tank_driver.sv
// Directed bench for ai_tank_driver with a frame-level behavioural model.
module tb_ai_tank_driver;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] ctl = 4'b0000;
    logic       tank_alive = 1'b1;
    logic       map_ack = 1'b0;
    logic       map_blocked = 1'b0;
    logic       fire_ack = 1'b0;
    logic       map_req;
    logic       fire_req;
    logic [9:0] map_x, map_y, tank_x, tank_y, fire_x, fire_y;
    logic [1:0] tank_dir, fire_dir;

    int vecs = 0;
    int errs = 0;
    int mx = 64, my = 32, mdir = 3, mcd = 0;
    int last_fx = 0, last_fy = 0, shots = 0;

    localparam int WIN = 90;

    always #5 Clk = ~Clk;

    ai_tank_driver dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .frame_tick      (frame_tick),
        .AI_tank_control (ctl),
        .tank_alive      (tank_alive),
        .map_req         (map_req),
        .map_x           (map_x),
        .map_y           (map_y),
        .map_ack         (map_ack),
        .map_blocked     (map_blocked),
        .tank_x          (tank_x),
        .tank_y          (tank_y),
        .tank_dir        (tank_dir),
        .fire_req        (fire_req),
        .fire_x          (fire_x),
        .fire_y          (fire_y),
        .fire_dir        (fire_dir),
        .fire_ack        (fire_ack)
    );

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: model computes the expected probes/position/shot, then the bench
    // plays map and bullet unit for WIN cycles and checks every meaningful cycle.
    task automatic run_frame(input logic [3:0] c, input bit alive, input int blk,
                             input int ack_dly, input bit no_ack, input int fhold,
                             input bit alive_drop);
        int dir, nx, ny, nexp, k, cyc, hi, fhi;
        int px[2];
        int py[2];
        bit ok, fire_exp, moved, ack_prev;

        if (mcd > 0) mcd--;
        dir = int'(c[1:0]);
        nx = mx;
        ny = my;
        case (dir)
            0:       begin nx = mx + 2; ok = (mx + 2 <= 608); end
            1:       begin nx = mx - 2; ok = (mx >= 2);       end
            2:       begin ny = my + 2; ok = (my + 2 <= 448); end
            default: begin ny = my - 2; ok = (my >= 2);       end
        endcase
        case (dir)
            0:       begin px[0] = nx + 31; py[0] = ny;      px[1] = nx + 31; py[1] = ny + 31; end
            1:       begin px[0] = nx;      py[0] = ny;      px[1] = nx;      py[1] = ny + 31; end
            2:       begin px[0] = nx;      py[0] = ny + 31; px[1] = nx + 31; py[1] = ny + 31; end
            default: begin px[0] = nx;      py[0] = ny;      px[1] = nx + 31; py[1] = ny;      end
        endcase
        if (!alive || !c[2] || !ok) nexp = 0;
        else if (no_ack || blk == 0) nexp = 1;
        else nexp = 2;
        moved = (nexp == 2) && (blk != 1) && !alive_drop;
        fire_exp = alive && c[3] && (mcd == 0) && !alive_drop;
        if (alive) mdir = dir;
        if (moved) begin mx = nx; my = ny; end

        ctl = c;
        tank_alive = alive;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        k = 0; cyc = 0; hi = 0; fhi = 0; ack_prev = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge Clk);
            map_ack = 1'b0;
            map_blocked = 1'b0;
            fire_ack = 1'b0;
            if (ack_prev) begin
                chk("map_req_drop_after_ack", int'(map_req), 0);
                ack_prev = 1'b0;
            end else if (map_req) begin
                hi++;
                if (k < nexp) begin
                    chk("map_x", int'(map_x), px[k]);
                    chk("map_y", int'(map_y), py[k]);
                end else begin
                    vecs++;
                    errs++;
                    $display("FAIL extra_probe: probe %0d seen, %0d expected", k + 1, nexp);
                end
                if (alive_drop) tank_alive = 1'b0;
                if (!no_ack && cyc == ack_dly) begin
                    map_ack = 1'b1;
                    map_blocked = (blk == k);
                    ack_prev = 1'b1;
                    k++;
                    cyc = 0;
                end else begin
                    cyc++;
                end
            end
            if (fire_req) begin
                fhi++;
                chk("fire_x", int'(fire_x), mx + 16);
                chk("fire_y", int'(fire_y), my + 16);
                chk("fire_dir", int'(fire_dir), mdir);
                last_fx = int'(fire_x);
                last_fy = int'(fire_y);
                if (fhi == fhold) fire_ack = 1'b1;
            end
        end
        tank_alive = 1'b1;
        if (no_ack) chk("timeout_hold_cycles", hi, 64);
        else chk("probe_count", k, nexp);
        chk("fire_hold_cycles", fhi, fire_exp ? fhold : 0);
        if (fhi > 0) shots++;
        chk("tank_x", int'(tank_x), mx);
        chk("tank_y", int'(tank_y), my);
        chk("tank_dir", int'(tank_dir), mdir);
        chk("map_req_idle", int'(map_req), 0);
        chk("fire_req_idle", int'(fire_req), 0);
        if (fire_exp) mcd = 30;
    endtask

    initial begin
        bit seen;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_tank_x", int'(tank_x), 64);
        chk("reset_tank_y", int'(tank_y), 32);
        chk("reset_tank_dir", int'(tank_dir), 3);
        chk("reset_map_req", int'(map_req), 0);
        chk("reset_fire_req", int'(fire_req), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // move right, clear map, ack on first cycle
        run_frame(4'b0100, 1'b1, -1, 0, 1'b0, 1, 1'b0);
        chk("lit_x_after_right", int'(tank_x), 66);
        chk("lit_dir_right", int'(tank_dir), 0);

        // walk up to the top edge, then one more up is out of bounds
        for (int f = 0; f < 16; f++) run_frame(4'b0111, 1'b1, -1, 0, 1'b0, 1, 1'b0);
        chk("lit_y_at_top", int'(tank_y), 0);
        run_frame(4'b0111, 1'b1, -1, 0, 1'b0, 1, 1'b0);
        chk("lit_dir_up_no_move", int'(tank_dir), 3);

        // down, second corner solid
        run_frame(4'b0110, 1'b1, 1, 0, 1'b0, 1, 1'b0);
        // left, first corner solid after a slow ack, then a clear left step
        run_frame(4'b0101, 1'b1, 0, 2, 1'b0, 1, 1'b0);
        run_frame(4'b0101, 1'b1, -1, 1, 1'b0, 1, 1'b0);
        chk("lit_x_after_left", int'(tank_x), 64);

        // shot with 3-cycle acceptance, then cooldown window of 30 frames
        run_frame(4'b1000, 1'b1, -1, 0, 1'b0, 3, 1'b0);
        chk("lit_fire_x", last_fx, 80);
        chk("lit_fire_y", last_fy, 16);
        for (int t = 1; t <= 30; t++)
            run_frame((t == 5 || t == 30) ? 4'b1000 : 4'b0000, 1'b1, -1, 0, 1'b0, 1, 1'b0);
        chk("lit_shots_over_cooldown", shots, 2);

        // map never answers
        run_frame(4'b0100, 1'b1, -1, 0, 1'b1, 1, 1'b0);
        // tank destroyed mid-probe, and a tick while dead
        run_frame(4'b1100, 1'b1, -1, 0, 1'b0, 1, 1'b1);
        run_frame(4'b0111, 1'b0, -1, 0, 1'b0, 1, 1'b0);

        // reset while PROBE0 is outstanding; late ack must be ignored
        ctl = 4'b0100;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (map_req) seen = 1'b1;
        end
        chk("probe_before_reset", int'(seen), 1);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("midreset_map_req", int'(map_req), 0);
        chk("midreset_fire_req", int'(fire_req), 0);
        chk("midreset_tank_x", int'(tank_x), 64);
        chk("midreset_tank_y", int'(tank_y), 32);
        chk("midreset_tank_dir", int'(tank_dir), 3);
        Reset_n = 1'b1;
        map_ack = 1'b1;
        repeat (3) @(negedge Clk);
        map_ack = 1'b0;
        repeat (3) @(negedge Clk);
        chk("late_ack_map_req", int'(map_req), 0);
        chk("late_ack_tank_x", int'(tank_x), 64);
        chk("late_ack_tank_y", int'(tank_y), 32);
        chk("late_ack_tank_dir", int'(tank_dir), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
